// File: rtl/ag_tcu_scale_seq_if.sv
// Handshake bundle for the scaled TCU micro-op sequencer:
// tile commands in, micro-ops out, retire pulses and scale updates.
interface ag_tcu_scale_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_m_steps;
    logic [2:0]  cmd_n_steps;
    logic [15:0] cmd_tag;
    logic        uop_valid;
    logic        uop_ready;
    logic [3:0]  uop_step_m;
    logic [3:0]  uop_step_n;
    logic [15:0] uop_tag;
    logic        uop_last;
    logic        retire;
    logic        scale_wr_valid;
    logic        scale_wr_ready;
    logic [8:0]  scale_wr_data;
    logic [8:0]  scale_combined;
    logic        busy;

    modport master (
        output cmd_valid, cmd_m_steps, cmd_n_steps, cmd_tag,
        output uop_ready, retire, scale_wr_valid, scale_wr_data,
        input  cmd_ready, uop_valid, uop_step_m, uop_step_n,
        input  uop_tag, uop_last, scale_wr_ready, scale_combined, busy
    );

    modport slave (
        input  cmd_valid, cmd_m_steps, cmd_n_steps, cmd_tag,
        input  uop_ready, retire, scale_wr_valid, scale_wr_data,
        output cmd_ready, uop_valid, uop_step_m, uop_step_n,
        output uop_tag, uop_last, scale_wr_ready, scale_combined, busy
    );
endinterface

// File: rtl/ag_tcu_scale_seq.sv
// Splits a tile command into m x n sub-block micro-ops (n inner),
// throttled by an inflight limit; owns the scale register.
module ag_tcu_scale_seq #(
    parameter int MAX_STEPS    = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                clk,
    input  logic                reset,
    ag_tcu_scale_seq_if.slave   io
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [3:0]    MAXS = 4'(MAX_STEPS);
    localparam logic [IW-1:0] MAXI = IW'(MAX_INFLIGHT);
    localparam logic [IW-1:0] ONE  = IW'(1);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    m_q, m_d, n_q, n_d;
    logic [3:0]    ms_q, ms_d, ns_q, ns_d;
    logic [15:0]   tag_q, tag_d;
    logic [IW-1:0] infl_q, infl_d;
    logic [8:0]    scale_q, scale_d;

    logic cmd_fire, uop_fire, scl_fire;
    logic n_end, last;

    function automatic logic [3:0] clamp(input logic [2:0] c);
        logic [3:0] w;
        w = {1'b0, c};
        if (w == 4'd0) return 4'd1;
        if (w > MAXS) return MAXS;
        return w;
    endfunction

    assign n_end = (n_q == ns_q - 4'd1);
    assign last  = n_end && (m_q == ms_q - 4'd1);

    assign io.uop_valid  = (state_q == ISSUE) && (infl_q < MAXI);
    assign io.uop_last   = (state_q == ISSUE) && last;
    assign io.uop_step_m = m_q;
    assign io.uop_step_n = n_q;
    assign io.uop_tag    = tag_q;
    assign io.scale_combined = scale_q;
    assign io.busy = (state_q != IDLE) || (infl_q != '0);

    // A pending scale write always wins over a command in IDLE.
    assign io.cmd_ready = !reset && (state_q == IDLE)
                          && !io.scale_wr_valid;
    assign io.scale_wr_ready = !reset && (state_q == IDLE)
                               && (infl_q == '0);

    assign cmd_fire = io.cmd_valid && io.cmd_ready;
    assign uop_fire = io.uop_valid && io.uop_ready;
    assign scl_fire = io.scale_wr_valid && io.scale_wr_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        ms_d    = ms_q;
        ns_d    = ns_q;
        tag_d   = tag_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    ms_d    = clamp(io.cmd_m_steps);
                    ns_d    = clamp(io.cmd_n_steps);
                    tag_d   = io.cmd_tag;
                    m_d     = 4'd0;
                    n_d     = 4'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (uop_fire) begin
                    if (last) begin
                        m_d     = 4'd0;
                        n_d     = 4'd0;
                        state_d = IDLE;
                    end else if (n_end) begin
                        n_d = 4'd0;
                        m_d = m_q + 4'd1;
                    end else begin
                        n_d = n_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        infl_d = infl_q;
        case ({uop_fire, io.retire})
            2'b10:   infl_d = infl_q + ONE;
            2'b01:   if (infl_q != '0) infl_d = infl_q - ONE;
            default: infl_d = infl_q;
        endcase
    end

    assign scale_d = scl_fire ? io.scale_wr_data : scale_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            ms_q    <= 4'd1;
            ns_q    <= 4'd1;
            tag_q   <= '0;
            infl_q  <= '0;
            scale_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            ms_q    <= ms_d;
            ns_q    <= ns_d;
            tag_q   <= tag_d;
            infl_q  <= infl_d;
            scale_q <= scale_d;
        end
    end
endmodule
